lab2_proc_test_mem_responder: RTL

- Single-port memory responder: the responder end of the processor's memory request/response val/rdy streams.
- Accepts one read or write request at a time, performs it on an internal word array, and returns the response after a fixed programmable delay.
- Holds the response under backpressure until it is consumed.
- Used in processor and cache test harnesses as the target of the imem/dmem request streams.

---
 rtl/lab2_proc_test_mem_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/lab2_proc_test_mem_responder.sv
// Memory responder for processor/cache test harnesses: accepts one val/rdy
// read or write request at a time on an internal word array and returns the
// response after p_latency extra cycles, holding it under backpressure.
// Optional request statistics: define LAB2_PROC_TEST_MEM_RESPONDER_STATS_EN.
module lab2_proc_test_mem_responder #(
    parameter int unsigned p_mem_words = 256,
    parameter int unsigned p_latency   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic        req_type,
    input  logic [7:0]  req_opaque,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_data,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic        resp_type,
    output logic [7:0]  resp_opaque,
    output logic [1:0]  resp_len,
    output logic [31:0] resp_data
`ifdef LAB2_PROC_TEST_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] num_reads,
    output logic [31:0] num_writes
`endif
);

    localparam int unsigned IDX_W = $clog2(p_mem_words);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        mem [p_mem_words];

    logic               accept;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         off;
    logic [4:0]         shamt;
    logic [3:0]         len_mask;
    logic [3:0]         wr_be;
    logic [31:0]        wr_word;
    logic [31:0]        rd_word;
    logic [31:0]        rd_data;
    logic               unused_addr_bits;

    assign accept           = req_val & req_rdy;
    assign unused_addr_bits = ^req_addr[31:IDX_W+2];

    // Address decode, write lane alignment and read data extraction
    always_comb begin
        idx      = req_addr[IDX_W+1:2];
        off      = req_addr[1:0];
        shamt    = {off, 3'b000};
        len_mask = 4'hF;
        case (req_len)
            2'd1:    len_mask = 4'h1;
            2'd2:    len_mask = 4'h3;
            2'd3:    len_mask = 4'h7;
            default: len_mask = 4'hF;
        endcase
        // lanes pushed past byte 3 fall off the top of the word
        wr_be   = 4'(len_mask << off);
        wr_word = 32'(req_data << shamt);
        rd_word = mem[idx];
        rd_data = (rd_word >> shamt)
                & {{8{len_mask[3]}}, {8{len_mask[2]}}, {8{len_mask[1]}}, {8{len_mask[0]}}};
    end

    // Array writes commit at the acceptance edge; contents are never reset
    always_ff @(posedge clk) begin
        if (accept && req_type) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered handshake outputs and response fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_rdy     <= 1'b0;
            resp_val    <= 1'b0;
            resp_type   <= 1'b0;
            resp_opaque <= '0;
            resp_len    <= '0;
            resp_data   <= '0;
`ifdef LAB2_PROC_TEST_MEM_RESPONDER_STATS_EN
            num_reads   <= '0;
            num_writes  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_rdy <= 1'b1;
                    if (accept) begin
                        req_rdy     <= 1'b0;
                        resp_type   <= req_type;
                        resp_opaque <= req_opaque;
                        resp_len    <= req_len;
                        resp_data   <= req_type ? 32'h0 : rd_data;
`ifdef LAB2_PROC_TEST_MEM_RESPONDER_STATS_EN
                        if (req_type) num_writes <= num_writes + 32'd1;
                        else          num_reads  <= num_reads + 32'd1;
`endif
                        if (p_latency > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_W'(p_latency);
                        end else begin
                            state    <= RESP;
                            resp_val <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state    <= RESP;
                        resp_val <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_rdy) begin
                        state    <= IDLE;
                        resp_val <= 1'b0;
                        req_rdy  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    req_rdy  <= 1'b0;
                    resp_val <= 1'b0;
                end
            endcase
        end
    end

endmodule
